// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Divides clk down to a pixel strobe, walks the x/y raster counters, and
// drives registered sync, data-enable and blanked green so that every pin
// lags the coordinate counters by exactly one pixel period.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_green_in,
    output logic [10:0] vga_xpos,
    output logic [9:0]  vga_ypos,
    output logic        pix_tick,
    output logic        video_active,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        vga_g
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    // Level driven on the sync pins while the pulse is asserted.
    localparam logic        SYNC_ON  = (SYNC_POL != 0);

    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic             pix_tick_reg;
    logic [10:0]      xpos_reg, xpos_next;
    logic [9:0]       ypos_reg, ypos_next;
    logic             frame_start_reg, frame_start_next;
    logic             hs_reg, vs_reg, de_reg, g_reg;
    logic             active_c, hs_c, vs_c, x_wrap, y_wrap;

    // Decode from the pre-increment counters; these feed the pin registers.
    always_comb begin
        active_c = (xpos_reg < H_ACT) && (ypos_reg < V_ACT);
        hs_c     = (xpos_reg >= HS_FIRST) && (xpos_reg <= HS_LAST);
        vs_c     = (ypos_reg >= VS_FIRST) && (ypos_reg <= VS_LAST);
        x_wrap   = (xpos_reg == H_LAST);
        y_wrap   = (ypos_reg == V_LAST);
    end

    // Next-state for the divider and the raster counters.
    always_comb begin
        div_cnt_next     = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_W'(1);
        xpos_next        = xpos_reg;
        ypos_next        = ypos_reg;
        frame_start_next = 1'b0;
        if (pix_tick_reg) begin
            if (x_wrap) begin
                xpos_next = '0;
                if (y_wrap) begin
                    ypos_next        = '0;
                    frame_start_next = 1'b1;
                end else begin
                    ypos_next = ypos_reg + 10'd1;
                end
            end else begin
                xpos_next = xpos_reg + 11'd1;
            end
        end
    end

    // State registers; the pin registers load only on the pixel strobe so
    // sync, de and green all share the same one-pixel lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg     <= '0;
            pix_tick_reg    <= 1'b0;
            xpos_reg        <= '0;
            ypos_reg        <= '0;
            frame_start_reg <= 1'b0;
            hs_reg          <= ~SYNC_ON;
            vs_reg          <= ~SYNC_ON;
            de_reg          <= 1'b0;
            g_reg           <= 1'b0;
        end else begin
            div_cnt_reg     <= div_cnt_next;
            // High during the clk in which the divider sits at its last count.
            pix_tick_reg    <= (div_cnt_next == DIV_LAST);
            xpos_reg        <= xpos_next;
            ypos_reg        <= ypos_next;
            frame_start_reg <= frame_start_next;
            if (pix_tick_reg) begin
                hs_reg <= hs_c ? SYNC_ON : ~SYNC_ON;
                vs_reg <= vs_c ? SYNC_ON : ~SYNC_ON;
                de_reg <= active_c;
                g_reg  <= vga_green_in & active_c;
            end
        end
    end

    assign vga_xpos     = xpos_reg;
    assign vga_ypos     = ypos_reg;
    assign pix_tick     = pix_tick_reg;
    assign video_active = active_c;
    assign frame_start  = frame_start_reg;
    assign vga_hs       = hs_reg;
    assign vga_vs       = vs_reg;
    assign vga_de       = de_reg;
    assign vga_g        = g_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster so that
// several whole frames fit in a short run. Expected outputs are derived
// from the number of clocks since reset release and queued one cycle ahead.
module tb_vga_timing_gen;

    localparam int D  = 2;
    localparam int HA = 16, HF = 4, HS = 6, HB = 4;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 30
    localparam int VT = VA + VF + VS + VB;   // 15
    localparam int F  = HT * VT;             // pixels per frame
    localparam int MID_N = 2 * F + 5 * HT + 20; // mid-frame reset at (20,5)
    localparam int RUN   = 3400;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_green_in;
    logic [10:0] vga_xpos;
    logic [9:0]  vga_ypos;
    logic        pix_tick, video_active, frame_start;
    logic        vga_hs, vga_vs, vga_de, vga_g;

    int compared_cnt = 0;
    int mismatch_cnt = 0;

    typedef struct {
        int x;
        int y;
        bit tick;
        bit act;
        bit fs;
        bit hs;
        bit vs;
        bit de;
        bit g;
    } exp_t;

    exp_t exp_q[$];

    vga_timing_gen #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
    ) dut (
        .clk(clk), .rst(rst), .vga_green_in(vga_green_in),
        .vga_xpos(vga_xpos), .vga_ypos(vga_ypos), .pix_tick(pix_tick),
        .video_active(video_active), .frame_start(frame_start),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_g(vga_g)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared_cnt++;
        if (got !== exp) begin
            mismatch_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Pixel advances that have taken effect by cycle k after release.
    function automatic int cnt_of(input int k);
        int r;
        r = (D >= 2) ? D - 2 : 0;
        return (k >= r + 1) ? (k - 1 - r) / D + 1 : 0;
    endfunction

    function automatic bit tick_of(input int k);
        return ((k + 1) % D) == (D - 1);
    endfunction

    // Overlay pattern for pixel number n; changes style each frame.
    function automatic bit green_of(input int n);
        int p, x, y;
        p = n % F;
        x = p % HT;
        y = p / HT;
        case ((n / F) % 4)
            0:       return 1'b1;
            1:       return (x == 9) && (y == 4);
            2:       return ((x ^ y) & 1) == 1;
            default: return ((x >> 1) & 1) == 1;
        endcase
    endfunction

    function automatic exp_t model(input int k);
        exp_t e;
        int n, p, q, px, py;
        e = '{x: 0, y: 0, tick: 1'b0, act: 1'b1, fs: 1'b0,
              hs: 1'b1, vs: 1'b1, de: 1'b0, g: 1'b0};
        if (k < 0) return e;
        n      = cnt_of(k);
        p      = n % F;
        e.x    = p % HT;
        e.y    = p / HT;
        e.tick = tick_of(k);
        e.act  = (e.x < HA) && (e.y < VA);
        if (n >= 1) begin
            q    = (n - 1) % F;
            px   = q % HT;
            py   = q / HT;
            e.hs = !((px >= HA + HF) && (px < HA + HF + HS));
            e.vs = !((py >= VA + VF) && (py < VA + VF + VS));
            e.de = (px < HA) && (py < VA);
            e.g  = e.de && green_of(n - 1);
            e.fs = (p == 0) && tick_of(k - 1);
        end
        return e;
    endfunction

    initial begin
        exp_t e;
        int   k_cur, k_next, rst_left;
        bit   mid_done;
        rst          = 1'b1;
        vga_green_in = 1'b0;
        exp_q.push_back(model(-1));
        k_cur    = -1;
        rst_left = 2;
        mid_done = 1'b0;
        for (int c = 0; c < RUN; c++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check_val("queue_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("xpos",         32'(vga_xpos),     32'(e.x));
                check_val("ypos",         32'(vga_ypos),     32'(e.y));
                check_val("pix_tick",     32'(pix_tick),     32'(e.tick));
                check_val("video_active", 32'(video_active), 32'(e.act));
                check_val("frame_start",  32'(frame_start),  32'(e.fs));
                check_val("vga_hs",       32'(vga_hs),       32'(e.hs));
                check_val("vga_vs",       32'(vga_vs),       32'(e.vs));
                check_val("vga_de",       32'(vga_de),       32'(e.de));
                check_val("vga_g",        32'(vga_g),        32'(e.g));
                if (e.tick && e.x == HT - 1)
                    $display("line y=%0d done at %0t (compared %0d)", e.y, $time, compared_cnt);
            end
            if (!mid_done && k_cur >= 0 && cnt_of(k_cur) == MID_N) begin
                rst_left = 3;
                mid_done = 1'b1;
                $display("mid-frame reset at pixel %0d", MID_N);
            end
            if (rst_left > 0) begin
                rst          = 1'b1;
                rst_left--;
                vga_green_in = 1'($urandom_range(0, 1));
                exp_q.push_back(model(-1));
                k_cur = -1;
            end else begin
                rst          = 1'b0;
                vga_green_in = (k_cur >= 0) ? green_of(cnt_of(k_cur)) : 1'b0;
                k_next       = (k_cur < 0) ? 0 : k_cur + 1;
                exp_q.push_back(model(k_next));
                k_cur = k_next;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
        $finish;
    end

endmodule
